mem_resp_merge: RTL and testbench

//  Return path for the core's data-memory load traffic. Reads are steered to the OCM (non-cacheable,

---
 rtl/mem_resp_merge.sv | 104 ++++++++++
 tb/tb_mem_resp_merge.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_resp_merge.sv
// mem_resp_merge: in-order merge of OCM (fixed latency) and cache (valid-qualified) load data back to the core.
module mem_resp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    // An empty FIFO forwards the word being pushed so it can be consumed in the same cycle.
    assign head = (cnt == '0) ? din : mem[rp];
endmodule

module mem_resp_merge #(
    parameter int DEPTH   = 2,
    parameter int OCM_LAT = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_req_ocm,
    input  logic        i_req_cache,
    input  logic [31:0] i_ocm_rdata,
    input  logic [31:0] i_cache_rdata,
    input  logic        i_cache_rvalid,
    input  logic        i_core_ready,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_req_ready,
    output logic        o_stall,
    output logic        o_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic               acc, acc_o, acc_c;
    logic [OCM_LAT-1:0] pipe;
    logic               o_push, c_push;
    logic [CW-1:0]      tag_cnt, o_cnt, c_cnt, pend;
    logic               head_tag;
    logic [31:0]        o_head, c_head;
    logic               loadable, load, pop_o, pop_c;

    assign o_req_ready = tag_cnt != CW'(DEPTH);
    assign acc      = (i_req_ocm ^ i_req_cache) && o_req_ready;
    assign acc_o    = acc && i_req_ocm;
    assign acc_c    = acc && i_req_cache;
    assign o_push   = pipe[OCM_LAT-1];
    // pend counts cache reads whose data has not yet arrived; data with none pending is stray.
    assign c_push   = i_cache_rvalid && (pend != '0);
    assign loadable = !o_rvalid || i_core_ready;
    assign load     = loadable && (tag_cnt != '0) &&
                      (head_tag ? (c_cnt != '0 || c_push) : (o_cnt != '0 || o_push));
    assign pop_o    = load && !head_tag;
    assign pop_c    = load && head_tag;
    assign o_stall  = (tag_cnt != '0) || o_rvalid;

    mem_resp_fifo #(.W(1), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .nrst(nrst), .push(acc), .din(acc_c), .pop(load),
        .head(head_tag), .cnt(tag_cnt)
    );
    mem_resp_fifo #(.W(32), .DEPTH(DEPTH)) u_ocm (
        .clk(clk), .nrst(nrst), .push(o_push), .din(i_ocm_rdata), .pop(pop_o),
        .head(o_head), .cnt(o_cnt)
    );
    mem_resp_fifo #(.W(32), .DEPTH(DEPTH)) u_cache (
        .clk(clk), .nrst(nrst), .push(c_push), .din(i_cache_rdata), .pop(pop_c),
        .head(c_head), .cnt(c_cnt)
    );

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            pipe     <= '0;
            pend     <= '0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            pipe     <= (pipe << 1) | OCM_LAT'(acc_o);
            pend     <= pend + CW'(acc_c) - CW'(c_push);
            o_rdata  <= load ? (head_tag ? c_head : o_head) : o_rdata;
            o_rvalid <= load ? 1'b1 : (loadable ? 1'b0 : o_rvalid);
            o_err    <= o_err | (i_req_ocm & i_req_cache) |
                        ((i_req_ocm | i_req_cache) & !o_req_ready) |
                        (i_cache_rvalid & (pend == '0));
        end
endmodule

// File: tb/tb_mem_resp_merge.sv
// tb_mem_resp_merge: directed vector table plus hand sequences for hold, full, error and reset cases.
module tb_mem_resp_merge;
    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req_ocm, i_req_cache, i_cache_rvalid, i_core_ready;
    logic [31:0] i_ocm_rdata, i_cache_rdata;
    logic [31:0] o_rdata;
    logic        o_rvalid, o_req_ready, o_stall, o_err;
    int          nvec = 0;
    int          nbad = 0;

    typedef struct {
        logic        ocm, cache;
        logic [31:0] odat, cdat;
        logic        cval, rdy;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_ready, e_stall, e_err;
    } vec_t;
    vec_t tbl [19];

    mem_resp_merge #(.DEPTH(2), .OCM_LAT(1)) dut (
        .clk(clk), .nrst(nrst),
        .i_req_ocm(i_req_ocm), .i_req_cache(i_req_cache),
        .i_ocm_rdata(i_ocm_rdata), .i_cache_rdata(i_cache_rdata),
        .i_cache_rvalid(i_cache_rvalid), .i_core_ready(i_core_ready),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_req_ready(o_req_ready),
        .o_stall(o_stall), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ocm, input logic cache, input logic [31:0] odat,
                         input logic [31:0] cdat, input logic cval, input logic rdy);
        i_req_ocm = ocm; i_req_cache = cache; i_ocm_rdata = odat;
        i_cache_rdata = cdat; i_cache_rvalid = cval; i_core_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic rv, input logic [31:0] rd,
                           input logic rr, input logic st, input logic er);
        chk({name, ".rvalid"}, 32'(o_rvalid), 32'(rv));
        chk({name, ".rdata"}, o_rdata, rd);
        chk({name, ".req_ready"}, 32'(o_req_ready), 32'(rr));
        chk({name, ".stall"}, 32'(o_stall), 32'(st));
        chk({name, ".err"}, 32'(o_err), 32'(er));
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        tick;
        tick;
        chk_all("reset", 0, 32'h0, 1, 0, 0);
        nrst = 1'b1;
    endtask

    function automatic vec_t mk(input logic ocm, input logic cache, input logic [31:0] odat,
                                input logic [31:0] cdat, input logic cval, input logic rdy,
                                input logic rv, input logic [31:0] rd, input logic rr,
                                input logic st, input logic er);
        vec_t v;
        v.ocm = ocm; v.cache = cache; v.odat = odat; v.cdat = cdat; v.cval = cval; v.rdy = rdy;
        v.e_rvalid = rv; v.e_rdata = rd; v.e_ready = rr; v.e_stall = st; v.e_err = er;
        return v;
    endfunction

    initial begin
        // OCM read, data one cycle later, single-cycle response
        tbl[0]  = mk(1, 0, 32'h0,        32'h0,        0, 1, 0, 32'h0,        1, 1, 0);
        tbl[1]  = mk(0, 0, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'hDEADBEEF, 1, 1, 0);
        tbl[2]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 0, 0);
        // cache read, data five cycles later
        tbl[3]  = mk(0, 1, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        tbl[4]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        tbl[6]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        tbl[7]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        tbl[8]  = mk(0, 0, 32'h0,        32'h12345678, 1, 1, 1, 32'h12345678, 1, 1, 0);
        tbl[9]  = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 1, 0, 0);
        // cache then OCM: OCM data waits behind the slower cache read
        tbl[10] = mk(0, 1, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 1, 1, 0);
        tbl[11] = mk(1, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 0, 1, 0);
        tbl[12] = mk(0, 0, 32'hA,        32'h0,        0, 1, 0, 32'h12345678, 0, 1, 0);
        tbl[13] = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 0, 1, 0);
        tbl[14] = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 0, 1, 0);
        tbl[15] = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 0, 1, 0);
        tbl[16] = mk(0, 0, 32'h0,        32'hB,        1, 1, 1, 32'hB,        1, 1, 0);
        tbl[17] = mk(0, 0, 32'h0,        32'h0,        0, 1, 1, 32'hA,        1, 1, 0);
        tbl[18] = mk(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hA,        1, 0, 0);

        do_reset;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].ocm, tbl[i].cache, tbl[i].odat, tbl[i].cdat, tbl[i].cval, tbl[i].rdy);
            tick;
            chk_all($sformatf("vec%0d", i), tbl[i].e_rvalid, tbl[i].e_rdata,
                    tbl[i].e_ready, tbl[i].e_stall, tbl[i].e_err);
        end

        // response held stable while the core is not ready
        do_reset;
        drive(1, 0, 0, 0, 0, 0); tick;
        drive(0, 0, 32'h55, 0, 0, 0); tick;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0); tick;
            chk_all($sformatf("hold%0d", i), 1, 32'h55, 1, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 1); tick;
        chk_all("hold_release", 0, 32'h55, 1, 0, 0);

        // fill the tag FIFO; the third request is dropped and flags an error
        drive(0, 1, 0, 0, 0, 1); tick;
        chk_all("full1", 0, 32'h55, 1, 1, 0);
        drive(0, 1, 0, 0, 0, 1); tick;
        chk_all("full2", 0, 32'h55, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 1); tick;
        chk_all("full_drop", 0, 32'h55, 0, 1, 1);
        drive(0, 0, 0, 32'h1, 1, 1); tick;
        chk_all("full_resp1", 1, 32'h1, 1, 1, 1);
        drive(0, 0, 0, 32'h2, 1, 1); tick;
        chk_all("full_resp2", 1, 32'h2, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 1); tick;
        chk_all("full_drain", 0, 32'h2, 1, 0, 1);

        // both sources requested at once: no tag, error
        do_reset;
        drive(1, 1, 0, 0, 0, 1); tick;
        chk_all("dual_req", 0, 32'h0, 1, 0, 1);
        drive(0, 0, 32'h77, 0, 0, 1); tick;
        chk_all("dual_after", 0, 32'h0, 1, 0, 1);

        // stray cache data with nothing outstanding
        do_reset;
        drive(0, 0, 0, 32'h99, 1, 1); tick;
        chk_all("stray", 0, 32'h0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1); tick;
        chk_all("stray_after", 0, 32'h0, 1, 0, 1);

        // asynchronous reset with two reads pending, then late cache data
        do_reset;
        drive(0, 1, 0, 0, 0, 1); tick;
        drive(0, 1, 0, 0, 0, 1); tick;
        chk_all("pend2", 0, 32'h0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        #2 nrst = 1'b0;
        #1 chk_all("async_rst", 0, 32'h0, 1, 0, 0);
        tick;
        #2 nrst = 1'b1;
        drive(0, 0, 0, 32'h5, 1, 1); tick;
        chk_all("late_rvalid", 0, 32'h0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
